ripple_count_capture: RTL
=========================

Name: ripple_count_capture

Overview:
- Downstream consumer of the 4-bit asynchronous ripple counter.
- Brings the counter's unsynchronised `count` bus into the system clock domain through a two-flop synchroniser. A sample is accepted only after it holds steady for STABLE_N cycles, which filters the ripple transients.
- Accumulates the modular increments into a wide running total.
- Reports the total and the event delta to the next stage through a valid/ready handshake.

Parameters:
- CW, 4: width of the ripple counter bus.
- ACC_W, 16: width of the running total and of the reported delta.
- STABLE_N, 2: consecutive identical synchronised samples required before a value is accepted (≥2).

Ports:
- clk  input  1  system clock. All state is updated on the rising edge.
- rst  input  1  synchronous, active-high reset.
- count_in  input  CW  raw ripple counter value (asynchronous to clk).
- clr  input  1  synchronous clear of the total, the report state and overflow.
- out_valid  output  1  report available.
- out_ready  input  1  downstream accepts the report.
- out_total  output  ACC_W  accumulated total at snapshot time.
- out_delta  output  ACC_W  events since the previous accepted report.
- overflow  output  1  sticky; set when the total wraps.
- locked  output  1  a baseline sample has been established.

Behaviour:
- Reset:
  - clk and rst are the only clock and reset. rst is synchronous and active-high, and is checked before all other logic.
  - On reset, all outputs and all internal registers go to 0: sync flops, stability counter, baseline, acc, last_reported, out_total, out_delta, out_valid, overflow, locked.
  - State goes to ACQ.
- Synchroniser:
  - s1 <= count_in, then s2 <= s1.
  - stab_cnt resets to 1 when s2 changes. Otherwise it increments and saturates at STABLE_N.
  - A sample is settled when stab_cnt == STABLE_N.
- FSM, ACQ state:
  - On the first settled sample: baseline <= s2, locked <= 1, go to RUN.
  - No accumulation happens in ACQ.
- FSM, RUN state:
  - On a settled sample with s2 != baseline: inc = (s2 - baseline) mod 2^CW, zero-extended to ACC_W. Then acc <= acc + inc and baseline <= s2.
  - The counter is treated as increment-only. An apparent decrement is a forward wrap; for example, 14→1 gives inc = 3.
  - Upstream must not advance 2^CW or more counts within one settle window. The block does not detect violations of this rule.
- Overflow:
  - If acc + inc carries out of ACC_W bits, acc keeps the wrapped value and overflow <= 1.
  - overflow stays set until rst or clr.
- Timing:
  - Once count_in is held steady, acc reflects the change 2+STABLE_N edges later.
  - out_valid rises on the following edge when the report is idle.
- Report handshake:
  - When out_valid == 0 and acc != last_reported: out_total <= acc, out_delta <= acc - last_reported (mod 2^ACC_W), out_valid <= 1.
  - While out_valid == 1, out_total and out_delta are held constant. out_valid does not drop until the edge where out_valid && out_ready; clr is the only exception.
  - On the accepting edge: out_valid <= 0 and last_reported <= out_total.
  - The next report can assert at the earliest one edge after acceptance.
  - Increments arriving while a report is pending keep accumulating in acc and appear in the next report.
- Simultaneous events:
  - Accept and accumulate in the same cycle: both take effect. last_reported takes the snapshot value, not the new acc.
  - clr and accept in the same cycle: clr wins. acc, last_reported, out_total, out_delta, out_valid and overflow all go to 0.
  - clr keeps baseline and locked, so counting continues from the current ripple value.
  - rst mid-report: out_valid drops immediately and state returns to ACQ.
- Upstream reset: the ripple counter shares rst, so its value after reset is 0. The ACQ state still takes the first settled sample rather than assuming 0.

Decomposition:
- Shared package: FSM state enum (ACQ, RUN) and default parameter constants (CW, ACC_W, STABLE_N).
- One sub-module: count_sync_filter. It contains the two-flop synchroniser and the STABLE_N stability counter, and outputs a settled strobe plus the value.
- The top level holds the FSM, the accumulator and the handshake.

Test Plan:
- Reset, then count_in held at 0 (STABLE_N=2) → locked=1 after 4 edges; out_valid stays 0; overflow=0.
- count_in steps 0→3 and holds, out_ready=1 → acc=3 after 4 edges; out_valid=1 with out_total=3, out_delta=3 one edge later; out_valid drops the edge after.
- Glitch: count_in 5 for one cycle, then 6 steady, starting from baseline 4 → exactly one accumulation of inc=2; 5 is never accepted.
- Wrap: baseline 14, count_in → 1 → inc=3; out_total increases by 3.
- Backpressure: out_ready=0 while count_in goes 0→2→7 → the first report holds out_total=2 and out_delta=2 stable. After out_ready=1, the next report is out_total=7, out_delta=5.
- Overflow and clr, with ACC_W=4: accumulate 15 then +3 → acc=2 and overflow=1. Then clr together with out_ready → out_valid=0, out_total=0, overflow=0, locked remains 1.

Source files
------------

// File: rtl/ripple_count_capture_pkg.sv
// Shared definitions for the ripple counter capture block: FSM state
// encoding and default widths/filter depth.
package ripple_count_capture_pkg;

    localparam int CW_DEF       = 4;
    localparam int ACC_W_DEF    = 16;
    localparam int STABLE_N_DEF = 2;

    typedef enum logic [0:0] {
        ST_ACQ = 1'b0,
        ST_RUN = 1'b1
    } state_e;

endpackage : ripple_count_capture_pkg

// File: rtl/ripple_count_capture_count_sync_filter.sv
// Two-flop synchroniser for the raw ripple bus followed by a stability
// counter. The value is reported as settled once it has been seen unchanged
// for STABLE_N consecutive cycles, which hides the ripple transients.
module count_sync_filter #(
    parameter int CW       = 4,
    parameter int STABLE_N = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] count_in,
    output logic          settled,
    output logic [CW-1:0] value
);

    localparam int SCW = $clog2(STABLE_N + 1);
    localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_N);

    logic [CW-1:0]  s1_q, s1_d;
    logic [CW-1:0]  s2_q, s2_d;
    logic [SCW-1:0] stab_q, stab_d;

    // Next-state: shift the synchroniser and restart the count when s2 changes.
    always_comb begin
        s1_d   = count_in;
        s2_d   = s1_q;
        stab_d = stab_q;
        if (s1_q != s2_q) begin
            stab_d = SCW'(1);
        end else if (stab_q < STAB_MAX) begin
            stab_d = stab_q + SCW'(1);
        end
    end

    // Synchroniser and stability counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            stab_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            stab_q <= stab_d;
        end
    end

    assign settled = (stab_q == STAB_MAX);
    assign value   = s2_q;

endmodule : count_sync_filter

// File: rtl/ripple_count_capture.sv
// Capture of an asynchronous 4-bit ripple counter: filters the synchronised
// bus, accumulates forward increments into a wide total, and publishes
// total/delta snapshots through a valid/ready handshake.
module ripple_count_capture
    import ripple_count_capture_pkg::*;
#(
    parameter int CW       = CW_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int STABLE_N = STABLE_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    count_in,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [ACC_W-1:0] out_delta,
    output logic             overflow,
    output logic             locked
);

    // The counter only counts up, so an apparent decrease is a forward wrap;
    // the modular difference already gives the right increment.
    function automatic logic [ACC_W-1:0] mod_inc(input logic [CW-1:0] now_v,
                                                 input logic [CW-1:0] base_v);
        logic [CW-1:0] diff;
        diff = now_v - base_v;
        return ACC_W'(diff);
    endfunction

    logic          settled;
    logic [CW-1:0] value;

    count_sync_filter #(
        .CW       (CW),
        .STABLE_N (STABLE_N)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .settled  (settled),
        .value    (value)
    );

    state_e           state_q, state_d;
    logic [CW-1:0]    base_q, base_d;
    logic             locked_q, locked_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] last_q, last_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [ACC_W-1:0] delta_q, delta_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             do_acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;

    // FSM, accumulator and report handshake next-state; clr overrides last.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        locked_d = locked_q;
        acc_d    = acc_q;
        last_d   = last_q;
        total_d  = total_q;
        delta_d  = delta_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        do_acc   = 1'b0;
        inc      = '0;

        case (state_q)
            ST_ACQ: begin
                // First settled sample becomes the baseline; nothing counted.
                if (settled) begin
                    base_d   = value;
                    locked_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (settled && (value != base_q)) begin
                    do_acc = 1'b1;
                    inc    = mod_inc(value, base_q);
                    base_d = value;
                end
            end
            default: state_d = ST_ACQ;
        endcase

        sum = {1'b0, acc_q} + {1'b0, inc};
        if (do_acc) begin
            acc_d = sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
                ovf_d = 1'b1;
            end
        end

        // Acceptance retires the snapshot actually shown, not the live acc,
        // so increments landing on the accept edge show up in the next report.
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = total_q;
        end else if (!valid_q && (acc_q != last_q)) begin
            total_d = acc_q;
            delta_d = acc_q - last_q;
            valid_d = 1'b1;
        end

        // Baseline and lock survive clr so counting resumes from the live value.
        if (clr) begin
            acc_d   = '0;
            last_d  = '0;
            total_d = '0;
            delta_d = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    // State registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ACQ;
            base_q   <= '0;
            locked_q <= 1'b0;
            acc_q    <= '0;
            last_q   <= '0;
            total_q  <= '0;
            delta_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            locked_q <= locked_d;
            acc_q    <= acc_d;
            last_q   <= last_d;
            total_q  <= total_d;
            delta_q  <= delta_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_total = total_q;
    assign out_delta = delta_q;
    assign overflow  = ovf_q;
    assign locked    = locked_q;

endmodule : ripple_count_capture
